// File: rtl/conv_enc_pkg.sv
// Shared constants for the tail-biting rate-1/3 K=7 convolutional encoder.
package conv_enc_pkg;

  localparam int K   = 7;
  localparam int MEM = K - 1;

  localparam logic [K-1:0] G0_DEF = 7'o133;
  localparam logic [K-1:0] G1_DEF = 7'o171;
  localparam logic [K-1:0] G2_DEF = 7'o165;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/conv_enc_skid.sv
// Two-entry valid/ready output buffer; outputs come straight from the head register.
module conv_enc_skid
  import conv_enc_pkg::*;
#(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_p0;
  logic [W-1:0] tail_p0;
  logic [1:0]   cnt_p0;
  logic         push;
  logic         pop;

  // in_ready is decoded from the occupancy register only, so m_ready never reaches s_ready
  assign in_ready  = (cnt_p0 != 2'd2);
  assign out_valid = (cnt_p0 != 2'd0);
  assign out_data  = head_p0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0  <= 2'd0;
      head_p0 <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_p0 <= cnt_p0 + 2'd1;
        2'b01:   cnt_p0 <= cnt_p0 - 2'd1;
        default: cnt_p0 <= cnt_p0;
      endcase
      if (push && ((cnt_p0 == 2'd0) || ((cnt_p0 == 2'd1) && pop)))
        head_p0 <= in_data;
      else if (pop && (cnt_p0 == 2'd2))
        head_p0 <= tail_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && (cnt_p0 == 2'd1) && !pop)
      tail_p0 <= in_data;
  end

endmodule

// File: rtl/conv_encoder_tb_stream.sv
// Tail-biting rate-1/3 K=7 convolutional encoder, PAR_W bits per cycle, ready/valid streams.
// Optional block counter output enabled by defining CONV_ENC_STATS_EN.
module conv_encoder_tb_stream
  import conv_enc_pkg::*;
#(
  parameter int           PAR_W = 8,
  parameter int           LEN_W = 13,
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF,
  parameter logic [K-1:0] G2    = G2_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [MEM-1:0]   cfg_tail,
  output logic             cfg_err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PAR_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PAR_W-1:0] m_d0,
  output logic [PAR_W-1:0] m_d1,
  output logic [PAR_W-1:0] m_d2,
  output logic             m_last
`ifdef CONV_ENC_STATS_EN
  ,
  output logic [15:0]      blk_count
`endif
);

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam int               SW  = 3*PAR_W + 1;

  state_t              state_p0;
  logic [LEN_W-1:0]    len_p0;
  logic [LEN_W-1:0]    cnt_p0;
  logic [MEM-1:0]      st_p0;
  logic                cfg_err_p0;
  logic                skid_ready;
  logic                acc;
  logic                is_last;
  logic [PAR_W+MEM-1:0] win;
  logic [K-1:0]        tap;
  logic [PAR_W-1:0]    d0, d1, d2;
  logic [SW-1:0]       skid_out;

  function automatic logic tap_parity(input logic [K-1:0] g, input logic [K-1:0] w);
    return ^(g & w);
  endfunction

  assign cfg_ready = (state_p0 == IDLE);
  assign cfg_err   = cfg_err_p0;
  assign s_ready   = (state_p0 == RUN) && skid_ready;
  assign acc       = s_valid && s_ready;
  assign is_last   = (cnt_p0 == (len_p0 - ONE));

  // Oldest bit sits at the top: st_p0[MEM-1] is s6, s_data[0] is the newest info bit.
  assign win = {st_p0, s_data};

  always_comb begin
    tap = '0;
    d0  = '0;
    d1  = '0;
    d2  = '0;
    for (int i = 0; i < PAR_W; i++) begin
      for (int j = 0; j < K; j++)
        tap[K-1-j] = win[i+j];
      d0[i] = tap_parity(G0, tap);
      d1[i] = tap_parity(G1, tap);
      d2[i] = tap_parity(G2, tap);
    end
  end

  // Stage p0: block control and shift-register state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= IDLE;
      len_p0     <= '0;
      cnt_p0     <= '0;
      st_p0      <= '0;
      cfg_err_p0 <= 1'b0;
    end else begin
      cfg_err_p0 <= 1'b0;
      case (state_p0)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_len == '0) begin
              cfg_err_p0 <= 1'b1;
            end else begin
              len_p0   <= cfg_len;
              st_p0    <= cfg_tail;
              cnt_p0   <= '0;
              state_p0 <= RUN;
            end
          end
        end
        RUN: begin
          if (acc) begin
            st_p0  <= win[MEM-1:0];
            cnt_p0 <= cnt_p0 + ONE;
            if (is_last)
              state_p0 <= IDLE;
          end
        end
      endcase
    end
  end

  // Stage p1: coded word held in the skid buffer
  conv_enc_skid #(
    .W(SW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (acc),
    .in_ready (skid_ready),
    .in_data  ({d0, d1, d2, is_last}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (skid_out)
  );

  assign {m_d0, m_d1, m_d2, m_last} = skid_out;

`ifdef CONV_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      blk_count <= 16'd0;
    else if (m_valid && m_ready && m_last)
      blk_count <= blk_count + 16'd1;
  end
`endif

endmodule
